// File: rtl/conv_window_sequencer.sv
// Window-walk read sequencer for a row-packed image RAM: one RAM read per kernel row,
// with the matching latched kernel row presented alongside the returning RAM data.
module conv_window_sequencer #(
    parameter int KSIZE  = 3,
    parameter int DW     = 8,
    parameter int ADDR_W = 8,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int STRIDE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [KSIZE*KSIZE*DW-1:0]   kernel_i,
    input  logic                        mac_ready_i,
    output logic                        ram_en_o,
    output logic [ADDR_W-1:0]           ram_addr_o,
    output logic [KSIZE*DW-1:0]         weight_o,
    output logic                        row_valid_o,
    output logic                        mac_clr_o,
    output logic                        win_last_o,
    output logic                        busy_o,
    output logic                        done_o
);

    // state | meaning
    // IDLE  | waiting for start; kernel snapshot taken on accept
    // RUN   | one row beat per cycle with mac_ready_i high
    // FLUSH | final beat's RAM read in flight
    // DONE  | final row_valid on the outputs; done pulses next cycle
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam int OUT_W = (IMG_W - KSIZE) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - KSIZE) / STRIDE + 1;
    localparam int ROW_W = KSIZE * DW;
    localparam int KW    = KSIZE * ROW_W;
    localparam int WR_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int WC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int KR_W  = $clog2(KSIZE);

    localparam logic [WR_W-1:0]   WR_LAST  = WR_W'(OUT_H - 1);
    localparam logic [WC_W-1:0]   WC_LAST  = WC_W'(OUT_W - 1);
    localparam logic [KR_W-1:0]   KR_LAST  = KR_W'(KSIZE - 1);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);

    state_t              state_q, state_d;
    logic [WR_W-1:0]     wr_q, wr_d;
    logic [WC_W-1:0]     wc_q, wc_d;
    logic [KR_W-1:0]     kr_q, kr_d;
    logic [KW-1:0]       kernel_q, kernel_d;
    logic                ram_en_q, ram_en_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [KR_W-1:0]     beat_kr_q, beat_kr_d;
    logic                row_valid_q, row_valid_d;
    logic [ROW_W-1:0]    weight_q, weight_d;
    logic                mac_clr_q, mac_clr_d;
    logic                win_last_q, win_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   addr_calc;
    logic [ROW_W-1:0]    w_sel;

    // Modular arithmetic in ADDR_W bits yields the same low bits as the full product.
    always_comb begin
        addr_calc = (ADDR_W'(wr_q) * STRIDE_A + ADDR_W'(kr_q)) * IMG_W_A
                    + ADDR_W'(wc_q) * STRIDE_A;
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < KSIZE; i++) begin
            if (beat_kr_q == KR_W'(i)) begin
                w_sel = kernel_q[(KSIZE-1-i)*ROW_W +: ROW_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        wc_d       = wc_q;
        kr_d       = kr_q;
        kernel_d   = kernel_q;
        ram_en_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        beat_kr_d  = beat_kr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // done_q high means this is the done cycle; starts there are dropped
                if (start_i && !done_q) begin
                    kernel_d = kernel_i;
                    wr_d     = '0;
                    wc_d     = '0;
                    kr_d     = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (mac_ready_i) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = addr_calc;
                    beat_kr_d  = kr_q;
                    if (kr_q == KR_LAST) begin
                        kr_d = '0;
                        if (wc_q == WC_LAST) begin
                            wc_d = '0;
                            if (wr_q == WR_LAST) begin
                                wr_d    = '0;
                                state_d = S_FLUSH;
                            end else begin
                                wr_d = wr_q + 1'b1;
                            end
                        end else begin
                            wc_d = wc_q + 1'b1;
                        end
                    end else begin
                        kr_d = kr_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        row_valid_d = ram_en_q;
        weight_d    = ram_en_q ? w_sel : weight_q;
        mac_clr_d   = ram_en_q && (beat_kr_q == '0);
        win_last_d  = ram_en_q && (beat_kr_q == KR_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_q        <= '0;
            wc_q        <= '0;
            kr_q        <= '0;
            kernel_q    <= '0;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            beat_kr_q   <= '0;
            row_valid_q <= 1'b0;
            weight_q    <= '0;
            mac_clr_q   <= 1'b0;
            win_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            wc_q        <= wc_d;
            kr_q        <= kr_d;
            kernel_q    <= kernel_d;
            ram_en_q    <= ram_en_d;
            ram_addr_q  <= ram_addr_d;
            beat_kr_q   <= beat_kr_d;
            row_valid_q <= row_valid_d;
            weight_q    <= weight_d;
            mac_clr_q   <= mac_clr_d;
            win_last_q  <= win_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ram_en_o    = ram_en_q;
    assign ram_addr_o  = ram_addr_q;
    assign weight_o    = weight_q;
    assign row_valid_o = row_valid_q;
    assign mac_clr_o   = mac_clr_q;
    assign win_last_o  = win_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: two instances (4x4 stride 1, 5x5 stride 2) share stimulus.
module tb_conv_window_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [71:0] kernel = '0;
    logic        mac_ready = 1'b0;

    logic        ram_en_a, row_valid_a, mac_clr_a, win_last_a, busy_a, done_a;
    logic [7:0]  ram_addr_a;
    logic [23:0] weight_a;
    logic        ram_en_b, row_valid_b, mac_clr_b, win_last_b, busy_b, done_b;
    logic [7:0]  ram_addr_b;
    logic [23:0] weight_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_done = 0;
    int nb_done = 0;
    int last_en_cyc = 0;
    int done_cyc = 0;
    bit mr_e = 1'b0;
    bit rst_e = 1'b1;
    bit prev_en = 1'b0;

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [23:0] qw[$];
    bit          qc[$];
    bit          ql[$];

    always #5 clk = ~clk;

    conv_window_sequencer #(.KSIZE(3), .DW(8), .ADDR_W(8), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .start_i(start), .kernel_i(kernel), .mac_ready_i(mac_ready),
        .ram_en_o(ram_en_a), .ram_addr_o(ram_addr_a), .weight_o(weight_a),
        .row_valid_o(row_valid_a), .mac_clr_o(mac_clr_a), .win_last_o(win_last_a),
        .busy_o(busy_a), .done_o(done_a));

    conv_window_sequencer #(.KSIZE(3), .DW(8), .ADDR_W(8), .IMG_W(5), .IMG_H(5), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .start_i(start), .kernel_i(kernel), .mac_ready_i(mac_ready),
        .ram_en_o(ram_en_b), .ram_addr_o(ram_addr_b), .weight_o(weight_b),
        .row_valid_o(row_valid_b), .mac_clr_o(mac_clr_b), .win_last_o(win_last_b),
        .busy_o(busy_b), .done_o(done_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: beat n belongs to window n/K, kernel row n%K; windows raster over a 2x2 output.
    function automatic int exp_addr(input int w, input int s, input int n);
        int win, kr, wr, wc;
        win = n / 3;
        kr  = n % 3;
        wr  = win / 2;
        wc  = win % 2;
        return (wr * s + kr) * w + wc * s;
    endfunction

    function automatic logic [23:0] krow(input logic [71:0] k, input int i);
        return k[(2-i)*24 +: 24];
    endfunction

    always @(posedge clk) begin
        cyc++;
        mr_e  = mac_ready;
        rst_e = rst;
    end

    always @(negedge clk) begin
        if (!rst_e) begin
            if (ram_en_a || prev_en) chk("row_valid_latency", 64'(row_valid_a), 64'(prev_en));
            if (ram_en_a) begin
                chk("en_needs_ready", 64'(mr_e), 64'd1);
                chk("busy_with_en", 64'(busy_a), 64'd1);
            end
            if (ram_en_a || ram_en_b) chk("en_b_match", 64'(ram_en_b), 64'(ram_en_a));
            if (!row_valid_a) chk("flag_without_valid", 64'({mac_clr_a, win_last_a}), 64'd0);
            if (row_valid_a || row_valid_b) chk("rv_b_match", 64'(row_valid_b), 64'(row_valid_a));
        end
        if (ram_en_a) begin
            qa.push_back(ram_addr_a);
            last_en_cyc = cyc;
        end
        if (ram_en_b) qb.push_back(ram_addr_b);
        if (row_valid_a) begin
            qw.push_back(weight_a);
            qc.push_back(mac_clr_a);
            ql.push_back(win_last_a);
        end
        if (done_a) begin
            n_done++;
            done_cyc = cyc;
        end
        if (done_b) nb_done++;
        prev_en = ram_en_a;
    end

    task automatic clear_log();
        qa.delete(); qb.delete(); qw.delete(); qc.delete(); ql.delete();
        n_done = 0;
        nb_done = 0;
    endtask

    // mode 0: ready always high; 1: ready 1,0,0 repeating; 2: random ready
    task automatic run_and_check(input int mode, input bit chg_k, input bit busy_start,
                                 input bit done_start, input logic [71:0] k);
        bit pulsed;
        pulsed = 1'b0;
        clear_log();
        @(posedge clk) #1;
        kernel    = k;
        start     = 1'b1;
        mac_ready = 1'b1;
        for (int c = 0; c < 600 && n_done == 0; c++) begin
            @(posedge clk) #1;
            start = 1'b0;
            case (mode)
                0:       mac_ready = 1'b1;
                1:       mac_ready = (c % 3 == 0);
                default: mac_ready = 1'($urandom_range(0, 1));
            endcase
            if (chg_k && c == 4) kernel = {8'($urandom), $urandom, $urandom};
            if (busy_start && c == 7) start = 1'b1;
            if (done_start && !pulsed && qw.size() == 12) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
        end
        start = 1'b0;
        chk("done_seen", 64'(n_done), 64'd1);
        @(negedge clk);
        chk("done_one_cycle", 64'(done_a), 64'd0);
        chk("busy_after_done", 64'(busy_a), 64'd0);
        repeat (4) @(negedge clk);
        chk("idle_stays_idle", 64'(busy_a), 64'd0);
        chk("beats_a", 64'(qa.size()), 64'd12);
        chk("beats_b", 64'(qb.size()), 64'd12);
        chk("row_valid_count", 64'(qw.size()), 64'd12);
        chk("done_count", 64'(n_done), 64'd1);
        chk("done_count_b", 64'(nb_done), 64'd1);
        chk("done_after_last_en", 64'(done_cyc - last_en_cyc), 64'd2);
        for (int i = 0; i < 12; i++) begin
            if (i < qa.size()) chk($sformatf("addr_a[%0d]", i), 64'(qa[i]), 64'(exp_addr(4, 1, i)));
            if (i < qb.size()) chk($sformatf("addr_b[%0d]", i), 64'(qb[i]), 64'(exp_addr(5, 2, i)));
            if (i < qw.size()) begin
                chk($sformatf("weight[%0d]", i), 64'(qw[i]), 64'(krow(k, i % 3)));
                chk($sformatf("mac_clr[%0d]", i), 64'(qc[i]), 64'(i % 3 == 0));
                chk($sformatf("win_last[%0d]", i), 64'(ql[i]), 64'(i % 3 == 2));
            end
        end
    endtask

    initial begin
        logic [71:0] k0;
        k0 = 72'h010203_040506_070809;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ram_en", 64'(ram_en_a), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr_a), 64'd0);
        chk("rst_weight", 64'(weight_a), 64'd0);
        chk("rst_row_valid", 64'(row_valid_a), 64'd0);
        chk("rst_flags", 64'({mac_clr_a, win_last_a}), 64'd0);
        chk("rst_busy_done", 64'({busy_a, done_a}), 64'd0);
        chk("rst_b_outputs", 64'({ram_en_b, ram_addr_b, row_valid_b, busy_b, done_b}), 64'd0);

        run_and_check(0, 1'b0, 1'b0, 1'b0, k0);
        run_and_check(1, 1'b0, 1'b0, 1'b0, k0);
        run_and_check(0, 1'b1, 1'b0, 1'b0, k0);
        run_and_check(0, 1'b0, 1'b1, 1'b0, {8'($urandom), $urandom, $urandom});
        run_and_check(1, 1'b0, 1'b0, 1'b1, {8'($urandom), $urandom, $urandom});
        for (int r = 0; r < 3; r++) begin
            run_and_check(2, 1'b1, 1'b1, 1'b0, {8'($urandom), $urandom, $urandom});
        end

        // abort a run after five issued beats
        clear_log();
        @(posedge clk) #1;
        kernel    = k0;
        start     = 1'b1;
        mac_ready = 1'b1;
        for (int c = 0; c < 100 && qa.size() < 5; c++) begin
            @(posedge clk) #1;
            start = 1'b0;
        end
        chk("rst_beats_reached", 64'(qa.size() >= 5), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ram_en", 64'(ram_en_a), 64'd0);
        chk("abort_ram_addr", 64'(ram_addr_a), 64'd0);
        chk("abort_weight", 64'(weight_a), 64'd0);
        chk("abort_valid_flags", 64'({row_valid_a, mac_clr_a, win_last_a}), 64'd0);
        chk("abort_busy_done", 64'({busy_a, done_a}), 64'd0);
        @(posedge clk) #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_done", 64'(n_done + nb_done), 64'd0);
        chk("abort_stays_idle", 64'(busy_a), 64'd0);

        run_and_check(0, 1'b0, 1'b0, 1'b0, k0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Parametrised successor to the single-kernel-size convolution input controller.
- Walks a KSIZE x KSIZE window over an IMG_H x IMG_W image held in a row-packed synchronous RAM, with configurable stride.
- For each window, issues KSIZE RAM reads, one per kernel row. Each read is paired with the matching kernel row so the downstream MAC receives data and weight on the same cycle.
- Adds a ready handshake, a kernel snapshot at start, window framing pulses and a done/busy indication.

Parameters:
- KSIZE, 3, kernel side length (>=2).
- DW, 8, bits per pixel/weight.
- ADDR_W, 8, RAM address width; IMG_W*IMG_H <= 2**ADDR_W.
- IMG_W, 16, image width in pixels.
- IMG_H, 16, image height in pixels.
- STRIDE, 1, window step in both directions (>=1). (IMG_W-KSIZE) and (IMG_H-KSIZE) must be divisible by STRIDE.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle, ignored while busy.
- kernel  in  KSIZE*KSIZE*DW  kernel; row 0 in MSBs, row KSIZE-1 in LSBs. Sampled on accepted start.
- mac_ready  in  1  downstream can accept a row beat this cycle.
- ram_en  out  1  RAM read enable.
- ram_addr  out  ADDR_W  RAM read address. Each RAM word holds KSIZE consecutive pixels starting at that pixel.
- weight  out  KSIZE*DW  kernel row aligned with RAM read data.
- row_valid  out  1  RAM data and weight valid for MAC this cycle.
- mac_clr  out  1  asserted with row_valid on the first row beat of each window.
- win_last  out  1  asserted with row_valid on the last row beat of each window.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Derived sizes: OUT_W=(IMG_W-KSIZE)/STRIDE+1, OUT_H=(IMG_H-KSIZE)/STRIDE+1.
- Counters: wr (window row 0..OUT_H-1), wc (window col 0..OUT_W-1), kr (kernel row 0..KSIZE-1).
- Reset: all outputs 0, counters 0, state IDLE, kernel register 0. Reset mid-run aborts immediately; no done pulse.
- FSM:
  - IDLE: on start, latch kernel, clear counters, assert busy, go to RUN.
  - RUN: a beat issues in any cycle with mac_ready=1. On issue:
    - ram_en=1.
    - ram_addr=(wr*STRIDE+kr)*IMG_W + wc*STRIDE.
    - Counters advance: kr first, then wc, then wr.
    - On the issue of (wr=OUT_H-1, wc=OUT_W-1, kr=KSIZE-1), go to FLUSH.
  - RUN with mac_ready=0: ram_en=0, counters and ram_addr hold.
  - FLUSH: one cycle so the final beat's row_valid appears, then done=1 for one cycle, busy=0, go to IDLE.
- ram_en and ram_addr are registered outputs.
- Latency: row_valid, weight, mac_clr and win_last are registered one cycle after the issuing cycle (RAM read latency 1). row_valid(t+1)=issue(t).
- weight for beat kr = latched kernel bits [(KSIZE-kr)*KSIZE*DW-1 : (KSIZE-kr-1)*KSIZE*DW].
- mac_clr=row_valid & (kr_of_beat==0); win_last=row_valid & (kr_of_beat==KSIZE-1).
- Address arithmetic is computed at full precision and truncated to ADDR_W. The parameter constraint guarantees no wrap.
- Kernel changes during a run have no effect; the latched copy is used.
- start coincident with done cycle: ignored. A new start is accepted from IDLE only, the cycle after done.
- Total beats per run = OUT_H*OUT_W*KSIZE. Exactly that many row_valid pulses per run.

Test Plan:
- KSIZE=3, IMG 4x4, STRIDE=1, mac_ready=1 -> 12 beats, addresses 0,4,8,1,5,9,4,8,12,5,9,13. mac_clr on beats 1,4,7,10; win_last on beats 3,6,9,12. done 2 cycles after the last ram_en.
- KSIZE=3, IMG 5x5, STRIDE=2 -> addresses 0,5,10,2,7,12,10,15,20,12,17,22.
- kernel=72'h010203_040506_070809, KSIZE=3, DW=8 -> weights 24'h010203, 24'h040506, 24'h070809 on successive beats. Changing kernel mid-run leaves weights unchanged.
- mac_ready toggling 1,0,0,1,... -> no ram_en and no row_valid while low. Address sequence identical to the first test; still exactly 12 row_valid pulses.
- rst asserted after beat 5 -> next cycle all outputs 0, busy=0, no done. A fresh start restarts at address 0.
- start pulsed while busy -> ignored; run completes with an unchanged beat count and a single done.
